mux_func_gen: RTL and testbench

Parametrised, registered Boolean function generator for the lab_3 combinational-logic series. It stores an N-variable truth table and evaluates it through a 2^SEL_W/1 multiplexer with residual per-input logic. The table can be reloaded serially at run time. An optional scan engine walks every minterm and reports where f = 1. At reset, the default table realises f(D,C,B,A) = ∑(3,5,6,7,9,10,11,12,13,14,15), so the block is a drop-in sequential successor of the 4-variable MX 4/1 exercise.

---
 rtl/mux_func_gen.sv | 161 ++++++++++++++++
 tb/tb_mux_func_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_func_gen.sv
// Registered N-variable Boolean function generator: truth table evaluated through a 2^SEL_W:1 mux,
// serial table reload, and an optional minterm scan engine enabled by `define MUX_FUNC_GEN_SCAN_EN.
module mux_func_gen #(
    parameter int                        N_VARS      = 4,
    parameter int                        SEL_W       = 2,
    parameter logic [(1<<N_VARS)-1:0]    RESET_TABLE = 16'hFEE8
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic [N_VARS-1:0] i_VARS,
    input  logic              i_EVAL,
    output logic [7:0]        o_Y,
    output logic              o_VALID,
    input  logic              i_LOAD_START,
    input  logic              i_LOAD_VALID,
    input  logic              i_LOAD_BIT,
    output logic              o_LOAD_READY,
    input  logic              i_SCAN_START,
    output logic [N_VARS-1:0] o_MINTERM,
    output logic              o_MT_VALID,
    output logic [N_VARS:0]   o_COUNT,
    output logic              o_SCAN_DONE,
    output logic [1:0]        o_state
);

    localparam int TBL_W   = 1 << N_VARS;
    localparam int RES_W   = N_VARS - SEL_W;
    localparam int SLICE_W = 1 << RES_W;
    localparam int MUX_W   = 1 << SEL_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SCAN = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [N_VARS-1:0] LAST_BIT = {N_VARS{1'b1}};
    localparam logic [N_VARS-1:0] ONE_N    = N_VARS'(1);

    // Handshake: a table bit is transferred on every rising edge where
    // o_LOAD_READY and i_LOAD_VALID are both high; i_LOAD_BIT is only sampled then.

    logic [1:0]        state_q;
    logic [TBL_W-1:0]  table_q;
    logic [TBL_W-1:0]  shadow_q;
    logic [TBL_W-1:0]  shadow_nxt;
    logic [N_VARS-1:0] bit_cnt_q;
    logic [7:0]        y_q;
    logic              valid_q;
    logic [MUX_W-1:0]  mux_in;
    logic [SEL_W-1:0]  mux_sel;
    logic              f_val;

    assign mux_sel = i_VARS[N_VARS-1 -: SEL_W];

    // Each mux data input is a residual function of the low variables.
    generate
        if (RES_W == 0) begin : g_no_residual
            assign mux_in = table_q;
        end else begin : g_residual
            for (genvar j = 0; j < MUX_W; j++) begin : g_slice
                logic [SLICE_W-1:0] slice;
                assign slice     = table_q[j*SLICE_W +: SLICE_W];
                assign mux_in[j] = slice[i_VARS[RES_W-1:0]];
            end
        end
    endgenerate

    assign f_val = mux_in[mux_sel];

    always_comb begin
        shadow_nxt            = shadow_q;
        shadow_nxt[bit_cnt_q] = i_LOAD_BIT;
    end

`ifdef MUX_FUNC_GEN_SCAN_EN
    localparam logic [N_VARS:0] SCAN_LAST = (N_VARS+1)'(TBL_W - 1);
    localparam logic [N_VARS:0] ONE_W     = (N_VARS+1)'(1);

    logic [N_VARS:0] scan_cnt_q;
    logic [N_VARS:0] count_q;
`endif

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q   <= IDLE;
            table_q   <= RESET_TABLE;
            shadow_q  <= '0;
            bit_cnt_q <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
`ifdef MUX_FUNC_GEN_SCAN_EN
            scan_cnt_q <= '0;
            count_q    <= '0;
`endif
        end else begin
            valid_q <= i_EVAL;
            if (i_EVAL) begin
                y_q <= {7'b0, f_val};
            end
            case (state_q)
                IDLE: begin
                    if (i_LOAD_START) begin
                        state_q   <= LOAD;
                        bit_cnt_q <= '0;
                        shadow_q  <= '0;
`ifdef MUX_FUNC_GEN_SCAN_EN
                    end else if (i_SCAN_START) begin
                        state_q    <= SCAN;
                        scan_cnt_q <= '0;
                        count_q    <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (i_LOAD_VALID) begin
                        shadow_q  <= shadow_nxt;
                        bit_cnt_q <= bit_cnt_q + ONE_N;
                        // The last bit commits the whole table on the same edge.
                        if (bit_cnt_q == LAST_BIT) begin
                            table_q <= shadow_nxt;
                            state_q <= IDLE;
                        end
                    end
                end
`ifdef MUX_FUNC_GEN_SCAN_EN
                SCAN: begin
                    if (table_q[scan_cnt_q[N_VARS-1:0]]) begin
                        count_q <= count_q + ONE_W;
                    end
                    scan_cnt_q <= scan_cnt_q + ONE_W;
                    if (scan_cnt_q == SCAN_LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_Y          = y_q;
    assign o_VALID      = valid_q;
    assign o_LOAD_READY = (state_q == LOAD);
    assign o_state      = state_q;

`ifdef MUX_FUNC_GEN_SCAN_EN
    assign o_MINTERM   = (state_q == SCAN) ? scan_cnt_q[N_VARS-1:0] : '0;
    assign o_MT_VALID  = (state_q == SCAN) & table_q[scan_cnt_q[N_VARS-1:0]];
    assign o_COUNT     = count_q;
    assign o_SCAN_DONE = (state_q == DONE);
`else
    logic unused_scan_start;
    assign unused_scan_start = i_SCAN_START;
    assign o_MINTERM   = '0;
    assign o_MT_VALID  = 1'b0;
    assign o_COUNT     = '0;
    assign o_SCAN_DONE = 1'b0;
`endif

endmodule

// File: tb/tb_mux_func_gen.sv
// Directed bench for mux_func_gen: reset table eval, scan, stalled load, mid-load reset,
// simultaneous starts and eval during scan. Scan expectations follow MUX_FUNC_GEN_SCAN_EN.
module tb_mux_func_gen;

    logic       i_CLK;
    logic       i_RST;
    logic [3:0] i_VARS;
    logic       i_EVAL;
    logic [7:0] o_Y;
    logic       o_VALID;
    logic       i_LOAD_START;
    logic       i_LOAD_VALID;
    logic       i_LOAD_BIT;
    logic       o_LOAD_READY;
    logic       i_SCAN_START;
    logic [3:0] o_MINTERM;
    logic       o_MT_VALID;
    logic [4:0] o_COUNT;
    logic       o_SCAN_DONE;
    logic [1:0] o_state;

    int checks   = 0;
    int failures = 0;

    mux_func_gen dut (
        .i_CLK        (i_CLK),
        .i_RST        (i_RST),
        .i_VARS       (i_VARS),
        .i_EVAL       (i_EVAL),
        .o_Y          (o_Y),
        .o_VALID      (o_VALID),
        .i_LOAD_START (i_LOAD_START),
        .i_LOAD_VALID (i_LOAD_VALID),
        .i_LOAD_BIT   (i_LOAD_BIT),
        .o_LOAD_READY (o_LOAD_READY),
        .i_SCAN_START (i_SCAN_START),
        .o_MINTERM    (o_MINTERM),
        .o_MT_VALID   (o_MT_VALID),
        .o_COUNT      (o_COUNT),
        .o_SCAN_DONE  (o_SCAN_DONE),
        .o_state      (o_state)
    );

    initial begin
        i_CLK = 1'b0;
        forever #5 i_CLK = ~i_CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: f(D,C,B,A) = sum(3,5,6,7,9..15)
    function automatic logic f_ref(input int v);
        return (v inside {3, 5, 6, 7, [9:15]});
    endfunction

    task automatic step();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] pat;
        int          idx;
        int          cyc;
        logic        v;

        i_RST = 1'b1; i_VARS = '0; i_EVAL = 1'b0;
        i_LOAD_START = 1'b0; i_LOAD_VALID = 1'b0; i_LOAD_BIT = 1'b0; i_SCAN_START = 1'b0;
        step();
        step();

        // Reset state
        check("rst_y", o_Y, 8'h00);
        check("rst_valid", o_VALID, 1'b0);
        check("rst_ready", o_LOAD_READY, 1'b0);
        check("rst_state", o_state, 2'd0);
        check("rst_count", o_COUNT, 5'd0);
        check("rst_done", o_SCAN_DONE, 1'b0);
        check("rst_mt", {o_MINTERM, o_MT_VALID}, 5'd0);
        i_RST = 1'b0;
        step();

        // Reset-table eval, back to back
        for (int k = 0; k < 16; k++) begin
            i_VARS = 4'(k);
            i_EVAL = 1'b1;
            step();
            check($sformatf("eval_y_%0d", k), o_Y, {7'b0, f_ref(k)});
            check($sformatf("eval_valid_%0d", k), o_VALID, 1'b1);
        end
        i_EVAL = 1'b0;
        step();
        check("eval_valid_drop", o_VALID, 1'b0);
        check("eval_y_hold", o_Y, 8'h01);

        i_VARS = 4'd0; i_EVAL = 1'b1;
        step();
        i_EVAL = 1'b0;
        check("eval_y_zero", o_Y, 8'h00);

        // Reset-table scan with an eval of minterm 12 in the middle
        i_SCAN_START = 1'b1;
        step();
        i_SCAN_START = 1'b0;
`ifdef MUX_FUNC_GEN_SCAN_EN
        for (int k = 0; k < 16; k++) begin
            check($sformatf("scan0_state_%0d", k), o_state, 2'd2);
            check($sformatf("scan0_mt_%0d", k), o_MINTERM, 4'(k));
            check($sformatf("scan0_mtv_%0d", k), o_MT_VALID, f_ref(k));
            check($sformatf("scan0_done_%0d", k), o_SCAN_DONE, 1'b0);
            if (k == 5) begin
                i_VARS = 4'd12;
                i_EVAL = 1'b1;
            end
            if (k == 6) begin
                check("scan_eval_y", o_Y, 8'h01);
                check("scan_eval_valid", o_VALID, 1'b1);
                i_EVAL = 1'b0;
            end
            step();
        end
        check("scan0_done", o_SCAN_DONE, 1'b1);
        check("scan0_count", o_COUNT, 5'd11);
        check("scan0_mt_off", {o_MINTERM, o_MT_VALID}, 5'd0);
        step();
        check("scan0_done_drop", o_SCAN_DONE, 1'b0);
        check("scan0_idle", o_state, 2'd0);
        check("scan0_count_hold", o_COUNT, 5'd11);
`else
        for (int k = 0; k < 4; k++) begin
            check($sformatf("noscan_state_%0d", k), o_state, 2'd0);
            check($sformatf("noscan_out_%0d", k), {o_MINTERM, o_MT_VALID, o_COUNT, o_SCAN_DONE}, 11'd0);
            step();
        end
        i_VARS = 4'd12; i_EVAL = 1'b1;
        step();
        i_EVAL = 1'b0;
        check("noscan_eval_y", o_Y, 8'h01);
`endif

        // Load 16'h0001 with a stall every third cycle
        pat = 16'h0001;
        i_LOAD_START = 1'b1;
        step();
        i_LOAD_START = 1'b0;
        check("load_state", o_state, 2'd1);
        check("load_ready", o_LOAD_READY, 1'b1);
        idx = 0;
        cyc = 0;
        while (idx < 16 && cyc < 64) begin
            v = (cyc % 3) != 2;
            i_LOAD_VALID = v;
            i_LOAD_BIT   = pat[idx];
            i_SCAN_START = (cyc == 1);
            // Eval on the final-bit edge must still see the old table (minterm 3 = 1)
            i_EVAL = v && (idx == 15);
            i_VARS = 4'd3;
            step();
            if (v) idx++;
            cyc++;
            if (idx < 16) check($sformatf("load_busy_%0d", cyc), o_state, 2'd1);
        end
        i_LOAD_VALID = 1'b0; i_SCAN_START = 1'b0; i_EVAL = 1'b0;
        check("load_bounded", idx, 16);
        check("load_stall_cycles", cyc, 23);
        check("load_old_table_y", o_Y, 8'h01);
        check("load_end_state", o_state, 2'd0);
        check("load_end_ready", o_LOAD_READY, 1'b0);
        i_VARS = 4'd0; i_EVAL = 1'b1;
        step();
        check("load_eval0", o_Y, 8'h01);
        i_VARS = 4'd15;
        step();
        check("load_eval15", o_Y, 8'h00);
        i_VARS = 4'd3;
        step();
        check("load_eval3", o_Y, 8'h00);
        i_EVAL = 1'b0;

`ifdef MUX_FUNC_GEN_SCAN_EN
        i_SCAN_START = 1'b1;
        step();
        i_SCAN_START = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("scan1_mtv_%0d", k), o_MT_VALID, (k == 0));
            step();
        end
        check("scan1_done", o_SCAN_DONE, 1'b1);
        check("scan1_count", o_COUNT, 5'd1);
        step();
`endif

        // Reset after 8 accepted bits of 16'h0000
        i_LOAD_START = 1'b1;
        step();
        i_LOAD_START = 1'b0;
        for (int k = 0; k < 8; k++) begin
            i_LOAD_VALID = 1'b1;
            i_LOAD_BIT   = 1'b0;
            step();
        end
        i_LOAD_VALID = 1'b0;
        check("midrst_pre_state", o_state, 2'd1);
        i_RST = 1'b1;
        step();
        i_RST = 1'b0;
        check("midrst_state", o_state, 2'd0);
        check("midrst_ready", o_LOAD_READY, 1'b0);
        check("midrst_y", o_Y, 8'h00);
        i_VARS = 4'd3; i_EVAL = 1'b1;
        step();
        i_EVAL = 1'b0;
        check("midrst_eval3", o_Y, 8'h01);
        check("midrst_eval3_valid", o_VALID, 1'b1);

        // Simultaneous starts: load wins, full-rate load of 16'h8001
        pat = 16'h8001;
        i_LOAD_START = 1'b1; i_SCAN_START = 1'b1;
        step();
        i_LOAD_START = 1'b0; i_SCAN_START = 1'b0;
        check("both_state", o_state, 2'd1);
        check("both_ready", o_LOAD_READY, 1'b1);
        for (int k = 0; k < 16; k++) begin
            i_LOAD_VALID = 1'b1;
            i_LOAD_BIT   = pat[k];
            step();
            check($sformatf("both_done_%0d", k), o_SCAN_DONE, 1'b0);
            check($sformatf("both_state_%0d", k), o_state, (k < 15) ? 2'd1 : 2'd0);
        end
        i_LOAD_VALID = 1'b0;
        step();
        check("both_no_done", o_SCAN_DONE, 1'b0);
        i_VARS = 4'd15; i_EVAL = 1'b1;
        step();
        check("both_eval15", o_Y, 8'h01);
        i_VARS = 4'd7;
        step();
        check("both_eval7", o_Y, 8'h00);
        i_EVAL = 1'b0;
        step();
        check("both_final_valid", o_VALID, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
